// File: rtl/enc_pkg.sv
// Error codes and controller states shared by the program-load encoder.
package enc_pkg;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_OPCODE,
        ERR_RANGE,
        ERR_ALIGN,
        ERR_WRAP
    } enc_err_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } enc_state_e;

endpackage

// File: rtl/opcodes_pkg.sv
// Shared opcode definitions for the instruction encoder and its users.
package opcodes_pkg;

    localparam int OPCODES_WIDTH = 4;

    // Codes 12..15 are unassigned and rejected by the encoder.
    typedef enum logic [OPCODES_WIDTH-1:0] {
        ADD_OP = 4'd0,
        SUB_OP = 4'd1,
        AND_OP = 4'd2,
        OR_OP  = 4'd3,
        MUL_OP = 4'd4,
        DIV_OP = 4'd5,
        XOR_OP = 4'd6,
        LW_OP  = 4'd7,
        SW_OP  = 4'd8,
        BEQ_OP = 4'd9,
        BLT_OP = 4'd10,
        BLE_OP = 4'd11
    } opcodes_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; the head word is visible on rdata while not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/opc_enc_32.sv
// Encodes instruction fields into 32-bit words and streams them into
// instruction memory from a base address, buffered through a small FIFO.
module opc_enc_32
    import opcodes_pkg::*;
    import enc_pkg::*;
#(
    parameter int  NUM_REG    = 32,
    parameter int  FIFO_DEPTH = 4,
    parameter int  ADDR_WIDTH = 10,
    localparam int REG_SELECT = $clog2(NUM_REG)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_last,
    input  opcodes_e              i_opcode,
    input  logic [REG_SELECT-1:0] i_sel_a,
    input  logic [REG_SELECT-1:0] i_sel_b,
    input  logic [REG_SELECT-1:0] i_sel_c,
    input  logic [31:0]           i_offset,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output enc_err_e              o_err
);
    localparam int IMM_WIDTH = 32 - OPCODES_WIDTH - 2 * REG_SELECT;

    enc_state_e            state;
    enc_state_e            state_d;
    enc_err_e              beat_err;
    logic [IMM_WIDTH-1:0]  imm;
    logic [31:0]           enc_word;
    logic [31:0]           fifo_rdata;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  addr_wrap;
    logic                  fits_mem;
    logic                  fits_branch;

    // An offset fits N signed bits when everything from bit N-1 upward is a pure sign extension.
    assign fits_mem    = (&i_offset[31:IMM_WIDTH-1]) | ~(|i_offset[31:IMM_WIDTH-1]);
    assign fits_branch = (&i_offset[31:IMM_WIDTH+1]) | ~(|i_offset[31:IMM_WIDTH+1]);

    always_comb begin
        beat_err = ERR_NONE;
        imm      = '0;
        case (i_opcode)
            ADD_OP, SUB_OP, AND_OP, OR_OP, MUL_OP, DIV_OP, XOR_OP: begin
                imm = {i_sel_c, {(IMM_WIDTH-REG_SELECT){1'b0}}};
            end
            LW_OP, SW_OP: begin
                imm = i_offset[IMM_WIDTH-1:0];
                if (!fits_mem) beat_err = ERR_RANGE;
            end
            BEQ_OP, BLT_OP, BLE_OP: begin
                imm = i_offset[IMM_WIDTH+1:2];
                if (i_offset[1:0] != 2'b00) beat_err = ERR_ALIGN;
                else if (!fits_branch)      beat_err = ERR_RANGE;
            end
            default: beat_err = ERR_OPCODE;
        endcase
    end

    assign enc_word  = {i_opcode, i_sel_a, i_sel_b, imm};
    assign o_ready   = (state == RUN) && !fifo_full;
    assign accept    = i_valid && o_ready;
    assign push      = accept && (beat_err == ERR_NONE);
    assign o_mem_we  = !fifo_empty;
    assign pop       = o_mem_we && i_mem_ready;
    assign addr_wrap = &addr[ADDR_WIDTH-1:2];
    assign o_mem_addr  = addr;
    assign o_mem_wdata = fifo_empty ? '0 : fifo_rdata;
    assign o_busy    = (state == RUN) || (state == DRAIN);
    assign o_done    = (state == DONE);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (accept && i_last) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the first error of a load is kept; a beat error wins over a same-cycle wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr  <= '0;
            o_err <= ERR_NONE;
        end else if (state == IDLE && i_start) begin
            addr  <= i_base_addr;
            o_err <= ERR_NONE;
        end else begin
            if (pop) addr <= addr + ADDR_WIDTH'(4);
            if (o_err == ERR_NONE) begin
                if (accept && beat_err != ERR_NONE) o_err <= beat_err;
                else if (pop && addr_wrap)          o_err <= ERR_WRAP;
            end
        end
    end

endmodule

// File: tb/tb_opc_enc_32.sv
// Self-checking bench for opc_enc_32: per-opcode vector table plus hand-written
// load sequences, with memory writes checked against a scoreboard queue.
module tb_opc_enc_32;
    import opcodes_pkg::*;
    import enc_pkg::*;

    localparam int AW = 10;
    localparam int NV = 15;

    typedef struct {
        opcodes_e    op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic [31:0] off;
        logic [17:0] imm;
        enc_err_e    err;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic          i_valid;
    logic          o_ready;
    logic          i_last;
    opcodes_e      i_opcode;
    logic [4:0]    i_sel_a;
    logic [4:0]    i_sel_b;
    logic [4:0]    i_sel_c;
    logic [31:0]   i_offset;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          i_mem_ready;
    logic          o_busy;
    logic          o_done;
    enc_err_e      o_err;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] exp_addr;
    wr_t           sb[$];
    vec_t          vecs[NV];

    opc_enc_32 #(.NUM_REG(32), .FIFO_DEPTH(4), .ADDR_WIDTH(AW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_last      (i_last),
        .i_opcode    (i_opcode),
        .i_sel_a     (i_sel_a),
        .i_sel_b     (i_sel_b),
        .i_sel_c     (i_sel_c),
        .i_offset    (i_offset),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ready (i_mem_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_word(input opcodes_e op, input logic [4:0] a,
                                             input logic [4:0] b, input logic [4:0] c);
        return {op, a, b, c, 13'b0};
    endfunction

    // Every completed write must match the oldest expected write.
    always @(negedge i_clk) begin : monitor
        wr_t e;
        if (i_rst_n && o_mem_we && i_mem_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual=0x%0h@0x%0h expected=none", o_mem_wdata, o_mem_addr);
            end else begin
                e = sb.pop_front();
                check_output("wr_addr", 32'(o_mem_addr), 32'(e.addr));
                check_output("wr_data", o_mem_wdata, e.data);
            end
        end
    end

    task automatic start_load(input logic [AW-1:0] base);
        @(posedge i_clk); #1;
        i_start     = 1'b1;
        i_base_addr = base;
        exp_addr    = base;
        @(posedge i_clk); #1;
        i_start     = 1'b0;
    endtask

    task automatic drive_fields(input opcodes_e op, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [31:0] off, input bit last);
        i_opcode = op;
        i_sel_a  = a;
        i_sel_b  = b;
        i_sel_c  = c;
        i_offset = off;
        i_last   = last;
        i_valid  = 1'b1;
    endtask

    task automatic handshake(input bit push_exp, input logic [31:0] word);
        int n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) check_output("ready_timeout", 32'(o_ready), 32'd1);
        else if (push_exp) begin
            sb.push_back('{exp_addr, word});
            exp_addr = exp_addr + AW'(4);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic apply_stimulus(input opcodes_e op, input logic [4:0] a, input logic [4:0] b,
                                  input logic [4:0] c, input logic [31:0] off, input bit last,
                                  input bit push_exp, input logic [31:0] word);
        drive_fields(op, a, b, c, off, last);
        handshake(push_exp, word);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge i_clk);
        while (!o_done && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check_output("done_pulse", 32'(o_done), 32'd1);
        @(negedge i_clk);
        check_output("done_one_cycle", 32'(o_done), 32'd0);
        check_output("idle_not_busy", 32'(o_busy), 32'd0);
        check_output("sb_drained", 32'(sb.size()), 32'd0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{ADD_OP, 5'd5,  5'd5,  5'd2,  32'd0,          18'h04000, ERR_NONE};
        vecs[1]  = '{SUB_OP, 5'd1,  5'd2,  5'd31, 32'd0,          18'h3E000, ERR_NONE};
        vecs[2]  = '{XOR_OP, 5'd31, 5'd0,  5'd1,  32'd0,          18'h02000, ERR_NONE};
        vecs[3]  = '{MUL_OP, 5'd3,  5'd4,  5'd5,  32'd0,          18'h0A000, ERR_NONE};
        vecs[4]  = '{LW_OP,  5'd7,  5'd8,  5'd0,  32'd100,        18'h00064, ERR_NONE};
        vecs[5]  = '{SW_OP,  5'd9,  5'd10, 5'd0,  32'hFFFF_FFFC,  18'h3FFFC, ERR_NONE};
        vecs[6]  = '{LW_OP,  5'd1,  5'd1,  5'd0,  32'd131071,     18'h1FFFF, ERR_NONE};
        vecs[7]  = '{LW_OP,  5'd2,  5'd2,  5'd0,  32'hFFFE_0000,  18'h20000, ERR_NONE};
        vecs[8]  = '{SW_OP,  5'd3,  5'd3,  5'd0,  32'd131072,     18'h00000, ERR_RANGE};
        vecs[9]  = '{BEQ_OP, 5'd4,  5'd5,  5'd0,  32'hFFFF_FFF8,  18'h3FFFE, ERR_NONE};
        vecs[10] = '{BLT_OP, 5'd6,  5'd7,  5'd0,  32'd12,         18'h00003, ERR_NONE};
        vecs[11] = '{BEQ_OP, 5'd1,  5'd2,  5'd0,  32'd6,          18'h00000, ERR_ALIGN};
        vecs[12] = '{BLE_OP, 5'd8,  5'd9,  5'd0,  32'd524284,     18'h1FFFF, ERR_NONE};
        vecs[13] = '{BLE_OP, 5'd8,  5'd9,  5'd0,  32'd524288,     18'h00000, ERR_RANGE};
        vecs[14] = '{opcodes_e'(4'd13), 5'd1, 5'd1, 5'd1, 32'd0,  18'h00000, ERR_OPCODE};

        i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        i_mem_ready = 1'b1; i_base_addr = '0; i_opcode = ADD_OP;
        i_sel_a = '0; i_sel_b = '0; i_sel_c = '0; i_offset = '0; exp_addr = '0;
        #2;
        check_output("rst_we",    32'(o_mem_we),    32'd0);
        check_output("rst_ready", 32'(o_ready),     32'd0);
        check_output("rst_busy",  32'(o_busy),      32'd0);
        check_output("rst_done",  32'(o_done),      32'd0);
        check_output("rst_addr",  32'(o_mem_addr),  32'd0);
        check_output("rst_wdata", o_mem_wdata,      32'd0);
        check_output("rst_err",   32'(o_err),       32'(ERR_NONE));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Single ADD beat at 0x100 against a hand-computed word.
        start_load(10'h100);
        check_output("run_busy", 32'(o_busy), 32'd1);
        apply_stimulus(ADD_OP, 5'd5, 5'd5, 5'd2, 32'd0, 1'b1, 1'b1, 32'h0294_4000);
        wait_done();

        // One load per table vector; each new start must clear the previous error.
        for (int i = 0; i < NV; i++) begin
            start_load(10'h100);
            check_output($sformatf("vec%0d_err_cleared", i), 32'(o_err), 32'(ERR_NONE));
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].off, 1'b1,
                           vecs[i].err == ERR_NONE, {vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm});
            wait_done();
            check_output($sformatf("vec%0d_err", i), 32'(o_err), 32'(vecs[i].err));
        end

        // Misaligned branch is dropped, later beats still written.
        start_load(10'h100);
        apply_stimulus(BEQ_OP, 5'd1, 5'd1, 5'd0, 32'd6, 1'b0, 1'b0, 32'd0);
        apply_stimulus(ADD_OP, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, alu_word(ADD_OP, 5'd1, 5'd2, 5'd3));
        apply_stimulus(SUB_OP, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1, 1'b1, alu_word(SUB_OP, 5'd4, 5'd5, 5'd6));
        wait_done();
        check_output("align_err", 32'(o_err), 32'(ERR_ALIGN));

        // Memory stall: four words fill the FIFO, the fifth beat waits.
        start_load(10'h100);
        i_mem_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            apply_stimulus(ADD_OP, 5'd1, 5'd2, 5'(k), 32'd0, 1'b0, 1'b1, alu_word(ADD_OP, 5'd1, 5'd2, 5'(k)));
        drive_fields(ADD_OP, 5'd1, 5'd2, 5'd4, 32'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            check_output("stall_ready", 32'(o_ready),    32'd0);
            check_output("stall_we",    32'(o_mem_we),   32'd1);
            check_output("stall_addr",  32'(o_mem_addr), 32'h100);
            check_output("stall_wdata", o_mem_wdata,     alu_word(ADD_OP, 5'd1, 5'd2, 5'd0));
        end
        @(posedge i_clk); #1;
        i_mem_ready = 1'b1;
        handshake(1'b1, alu_word(ADD_OP, 5'd1, 5'd2, 5'd4));
        apply_stimulus(ADD_OP, 5'd1, 5'd2, 5'd5, 32'd0, 1'b1, 1'b1, alu_word(ADD_OP, 5'd1, 5'd2, 5'd5));
        wait_done();
        check_output("stall_err", 32'(o_err), 32'(ERR_NONE));

        // Address wrap from the top of memory.
        start_load(10'h3FC);
        apply_stimulus(ADD_OP, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b1, alu_word(ADD_OP, 5'd1, 5'd1, 5'd1));
        apply_stimulus(ADD_OP, 5'd2, 5'd2, 5'd2, 32'd0, 1'b1, 1'b1, alu_word(ADD_OP, 5'd2, 5'd2, 5'd2));
        wait_done();
        check_output("wrap_err", 32'(o_err), 32'(ERR_WRAP));

        // Reset while draining three stalled words.
        start_load(10'h100);
        i_mem_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            apply_stimulus(OR_OP, 5'd3, 5'd3, 5'(k), 32'd0, k == 2, 1'b1, alu_word(OR_OP, 5'd3, 5'd3, 5'(k)));
        @(negedge i_clk);
        check_output("drain_busy", 32'(o_busy),   32'd1);
        check_output("drain_we",   32'(o_mem_we), 32'd1);
        @(posedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        check_output("mid_rst_we",    32'(o_mem_we),   32'd0);
        check_output("mid_rst_addr",  32'(o_mem_addr), 32'd0);
        check_output("mid_rst_wdata", o_mem_wdata,     32'd0);
        check_output("mid_rst_busy",  32'(o_busy),     32'd0);
        check_output("mid_rst_ready", 32'(o_ready),    32'd0);
        sb.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n     = 1'b1;
        i_mem_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        check_output("post_rst_idle", 32'(o_busy),   32'd0);
        check_output("post_rst_we",   32'(o_mem_we), 32'd0);
        @(posedge i_clk); #1;
        start_load(10'h100);
        apply_stimulus(AND_OP, 5'd7, 5'd7, 5'd7, 32'd0, 1'b1, 1'b1, alu_word(AND_OP, 5'd7, 5'd7, 5'd7));
        wait_done();
        check_output("post_rst_err", 32'(o_err), 32'(ERR_NONE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opc_enc_32.md
OPC_ENC_32 -- requirements
Module: opc_enc_32

Interface
REQ-001 The module SHALL take parameter NUM_REG, default 32, as the register count; REG_SELECT = $clog2(NUM_REG).
REQ-002 The module SHALL take parameter FIFO_DEPTH, default 4, as the encoded-word buffer depth (power of two, >= 2).
REQ-003 The module SHALL take parameter ADDR_WIDTH, default 10, as the byte-address width of the instruction-memory write port.
REQ-004 Ports (name, direction, width, meaning):
- i_clk, in, 1: the single clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_start, in, 1: begin a program load.
- i_base_addr, in, ADDR_WIDTH: first write address.
- i_valid, in, 1: instruction fields valid.
- o_ready, out, 1: encoder accepts fields.
- i_last, in, 1: current beat is the last instruction.
- i_opcode, in, opcodes_e: operation.
- i_sel_a, i_sel_b, i_sel_c, in, REG_SELECT each: register selects.
- i_offset, in, 32: signed byte offset.
- o_mem_we, out, 1: write strobe.
- o_mem_addr, out, ADDR_WIDTH: write address.
- o_mem_wdata, out, 32: encoded word.
- i_mem_ready, in, 1: memory accepts the write.
- o_busy, out, 1: load in progress.
- o_done, out, 1: one-cycle completion pulse.
- o_err, out, enc_err_e: sticky error code.

Function
REQ-005 The word SHALL be encoded as [31 -: OPCODES_WIDTH] = opcode, then sel_a, then sel_b, with the low IMMEDIATE_WIDTH = 32 - OPCODES_WIDTH - 2*REG_SELECT bits forming the immediate field.
REQ-006 For ADD/SUB/AND/OR/MUL/DIV/XOR, the immediate field SHALL be {sel_c, zeros}.
REQ-007 For LW and SW, the immediate field SHALL be i_offset[IMMEDIATE_WIDTH-1:0]; i_offset SHALL fit in IMMEDIATE_WIDTH signed bits, otherwise ERR_RANGE.
REQ-008 For BEQ/BLT/BLE, the immediate field SHALL be i_offset[IMMEDIATE_WIDTH+1:2]; i_offset[1:0] != 0 SHALL give ERR_ALIGN; a value not fitting IMMEDIATE_WIDTH+2 signed bits SHALL give ERR_RANGE.
REQ-009 Any other opcode SHALL give ERR_OPCODE.
REQ-010 An erroring beat SHALL be consumed and not enqueued; the first error SHALL be latched in o_err until the next i_start; later beats continue to be encoded.
REQ-011 FSM states SHALL be IDLE, RUN, DRAIN and DONE:
- IDLE to RUN on i_start; the address counter is loaded with i_base_addr and o_err is cleared.
- RUN to DRAIN on an accepted beat with i_last.
- DRAIN to DONE when the FIFO is empty and no write is pending.
- DONE to IDLE unconditionally after one cycle, asserting o_done.
REQ-012 o_ready SHALL be 1 only in RUN with the FIFO not full; a beat is accepted when i_valid && o_ready.
REQ-013 An accepted valid word SHALL be registered into the FIFO; its earliest o_mem_we is the next cycle (latency 1).
REQ-014 o_mem_we SHALL be asserted while the FIFO is non-empty. The head word is popped, and the address increments by 4, only on o_mem_we && i_mem_ready. o_mem_addr and o_mem_wdata SHALL hold stable while stalled.
REQ-015 On simultaneous push and pop when full, the push SHALL be refused (o_ready is low when full); on simultaneous push and pop otherwise, the occupancy SHALL be unchanged.
REQ-016 An address increment past 2^ADDR_WIDTH-4 SHALL wrap to 0 and latch ERR_WRAP if o_err is ERR_NONE.
REQ-017 i_start SHALL be ignored outside IDLE.
REQ-018 If i_last arrives on an erroring beat, the FSM SHALL still go to DRAIN.
REQ-019 o_busy SHALL be high in RUN and DRAIN.

Reset
REQ-020 Asserting i_rst_n low at any time, including mid-load, SHALL immediately force:
- state to IDLE and the FIFO to empty;
- o_mem_we, o_ready, o_busy and o_done to 0;
- o_mem_addr and o_mem_wdata to 0;
- o_err to ERR_NONE.
REQ-021 In-flight words SHALL be discarded on reset.

Structure
REQ-022 enc_err_e {ERR_NONE, ERR_OPCODE, ERR_RANGE, ERR_ALIGN, ERR_WRAP} SHALL be defined in a new shared package enc_pkg; opcodes_e and OPCODES_WIDTH SHALL come from opcodes_pkg.
REQ-023 The FIFO SHALL be a separate sub-module sync_fifo, parameterised by width and depth, with push/pop/full/empty.

Verification
REQ-024 NUM_REG=32. Beat {ADD_OP, a=5, b=5, c=2} with i_base_addr=0x100 -> one write at 0x100 of {ADD_OP, 5'd5, 5'd5, 5'd2, zeros}, then o_done.
REQ-025 BEQ with i_offset=-8 -> immediate field = sign-extended -2. BEQ with i_offset=6 -> ERR_ALIGN, no write, following beats still written.
REQ-026 i_mem_ready held low 10 cycles with 6 beats offered -> exactly FIFO_DEPTH words buffered, o_ready low, address/data stable; release -> addresses 0x100, 0x104, ... in order, no loss.
REQ-027 i_base_addr = 2^ADDR_WIDTH-4, two beats -> writes at 0x3FC then 0x000, o_err = ERR_WRAP.
REQ-028 i_rst_n low during DRAIN with 3 words queued -> outputs zero immediately, no further writes, IDLE after release; a new i_start works normally.
REQ-029 Undefined opcode value -> ERR_OPCODE latched, cleared by the next i_start.
